// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore control FSM for the 32-bit multicycle MIPS core. One state per
//   cycle; every output decodes from the current state, except PCWrite in
//   BRANCH, which is qualified by Zero.
//
// Ports
//   clk        core clock, rising edge
//   reset      synchronous, active-low reset (returns to FETCH)
//   Op, Funct  instruction fields Instr[31:26] / Instr[5:0]
//   Zero       ALU result is zero
//   PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
//   ALUSrcA, gpio_i, ALUSrcB, ALUControl
//              datapath strobes / mux selects, one-to-one with the datapath
//   State_o    current state encoding (debug)
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               RegWrite,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         gpio_i,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JAL_WB   = 4'd13,
    S_JR       = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_INSW  = 6'b011111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // Strobes before the reset gate; reset low must suppress every write.
  logic pc_write_s, reg_write_s, mem_write_s, ir_write_s;

  function automatic logic funct_known(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    gpio_i      = 2'b01;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;

    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        pc_write_s = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= PC+4 + (SignImm<<2), the branch target.
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Op)
          OP_LW, OP_SW:                        state_d = S_MEMADR;
          OP_RTYPE: state_d = (Funct == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_LUI, OP_INSW:   state_d = S_IMM_EX;
          OP_J:                                state_d = S_JUMP;
          OP_JAL:                              state_d = S_JAL;
          default:                             state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        IorD        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu(Funct);
        // Unknown Funct retires here without a writeback.
        state_d    = funct_known(Funct) ? S_ALU_WB : S_FETCH;
      end
      S_ALU_WB: begin
        RegDst      = 2'b01;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        pc_write_s = (Op == OP_BNE) ? !Zero : Zero;
      end
      S_IMM_EX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        case (Op)
          OP_SLTI: ALUControl = ALU_SLT;
          OP_LUI:  gpio_i     = 2'b00;
          OP_INSW: gpio_i     = 2'b10;
          default: gpio_i     = 2'b01;
        endcase
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write_s = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write_s = 1'b1;
      end
      S_JAL: begin
        // ALUOut captures PC (already PC+4) + 0 for the link write.
        ALUSrcB    = 2'b10;
        gpio_i     = 2'b11;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_JAL_WB;
      end
      S_JAL_WB: begin
        RegDst      = 2'b10;
        reg_write_s = 1'b1;
      end
      S_JR: begin
        // PC <= rs + 0 straight from the ALU.
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        gpio_i     = 2'b11;
        ALUControl = ALU_ADD;
        pc_write_s = 1'b1;
      end
      default: begin
        gpio_i = 2'b00;
      end
    endcase
  end

  assign PCWrite  = pc_write_s  & reset;
  assign RegWrite = reg_write_s & reset;
  assign MemWrite = mem_write_s & reset;
  assign IRWrite  = ir_write_s  & reset;
  assign State_o  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, RegWrite, IorD, MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic [1:0] PCSrc, RegDst, gpio_i, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State_o;

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .gpio_i(gpio_i),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .State_o(State_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       rw;
    logic       iord;
    logic       mw;
    logic       irw;
    logic [1:0] regdst;
    logic       m2r;
    logic       srca;
    logic [1:0] gpio;
    logic [1:0] srcb;
    logic [2:0] aluc;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   seq[8];
  int   seq_len;

  function automatic ctl_t mk(bit pcw, bit [1:0] pcsrc, bit rw, bit iord,
                              bit mw, bit irw, bit [1:0] regdst, bit m2r,
                              bit srca, bit [1:0] gpio, bit [1:0] srcb,
                              bit [2:0] aluc);
    ctl_t c;
    c = '{pcw, pcsrc, rw, iord, mw, irw, regdst, m2r, srca, gpio, srcb, aluc};
    return c;
  endfunction

  // Instruction class -> list of visited states, straight from the latency table.
  function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn);
    seq[0] = 0; seq[1] = 1; seq_len = 2;
    case (op)
      6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; seq_len = 5; end
      6'b101011: begin seq[2] = 2; seq[3] = 5; seq_len = 4; end
      6'b000000: begin
        if (fn == 6'b001000) begin seq[2] = 14; seq_len = 3; end
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          begin seq[2] = 6; seq[3] = 7; seq_len = 4; end
        else begin seq[2] = 6; seq_len = 3; end
      end
      6'b000100, 6'b000101: begin seq[2] = 8; seq_len = 3; end
      6'b001000, 6'b001010, 6'b001111, 6'b011111:
        begin seq[2] = 9; seq[3] = 10; seq_len = 4; end
      6'b000010: begin seq[2] = 11; seq_len = 3; end
      6'b000011: begin seq[2] = 12; seq[3] = 13; seq_len = 4; end
      default: ;
    endcase
  endfunction

  // Expected control word for a state, from the per-state output table.
  function automatic ctl_t ref_ctl(input int st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z,
                                   input logic rstn);
    ctl_t c;
    bit [2:0] a;
    case (st)
      0:  c = mk(1,0,0,0,0,1,0,0,0,1,1,2);
      1:  c = mk(0,0,0,0,0,0,0,0,0,1,3,2);
      2:  c = mk(0,0,0,0,0,0,0,0,1,1,2,2);
      3:  c = mk(0,0,0,1,0,0,0,0,0,1,0,0);
      4:  c = mk(0,0,1,0,0,0,0,1,0,1,0,0);
      5:  c = mk(0,0,0,1,1,0,0,0,0,1,0,0);
      6: begin
        case (fn)
          6'b100010: a = 3'b110;
          6'b100100: a = 3'b000;
          6'b100101: a = 3'b001;
          6'b101010: a = 3'b111;
          default:   a = 3'b010;
        endcase
        c = mk(0,0,0,0,0,0,0,0,1,1,0,a);
      end
      7:  c = mk(0,0,1,0,0,0,1,0,0,1,0,0);
      8:  c = mk((op == 6'b000101) ? !z : z, 1,0,0,0,0,0,0,1,1,0,6);
      9: begin
        if (op == 6'b001010)      c = mk(0,0,0,0,0,0,0,0,1,1,2,7);
        else if (op == 6'b001111) c = mk(0,0,0,0,0,0,0,0,1,0,2,2);
        else if (op == 6'b011111) c = mk(0,0,0,0,0,0,0,0,1,2,2,2);
        else                      c = mk(0,0,0,0,0,0,0,0,1,1,2,2);
      end
      10: c = mk(0,0,1,0,0,0,0,0,0,1,0,0);
      11: c = mk(1,2,0,0,0,0,0,0,0,1,0,0);
      12: c = mk(1,2,0,0,0,0,0,0,0,3,2,2);
      13: c = mk(0,0,1,0,0,0,2,0,0,1,0,0);
      14: c = mk(1,0,0,0,0,0,0,0,1,3,2,2);
      default: c = '0;
    endcase
    if (!rstn) begin
      c.pcw = 1'b0; c.rw = 1'b0; c.mw = 1'b0; c.irw = 1'b0;
    end
    return c;
  endfunction

  // One cycle: drive reset/Zero, push the expected response, advance.
  task automatic step(input int st, input logic rstn, input int zmode);
    exp_t e;
    reset = rstn;
    Zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    e.st  = 4'(st);
    e.c   = ref_ctl(st, Op, Funct, Zero, rstn);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // inj >= 0: reset held low during that step of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int inj);
    Op = op;
    Funct = fn;
    build_seq(op, fn);
    for (int i = 0; i < seq_len; i++) begin
      if (i == inj) begin
        step(seq[i], 1'b0, zmode);
        return;
      end
      step(seq[i], 1'b1, zmode);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is checked.
  always @(negedge clk) begin
    exp_t e;
    ctl_t got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = '{PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite, RegDst,
              MemtoReg, ALUSrcA, gpio_i, ALUSrcB, ALUControl};
      total++;
      if (State_o !== e.st) begin
        bad++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, State_o, e.st);
      end
      total++;
      if (got !== e.c) begin
        bad++;
        $display("FAIL ctl t=%0t st=%0d got=%h want=%h", $time, e.st, got, e.c);
      end
    end
  end

  logic [5:0] op_tab[12];
  logic [5:0] fn_tab[7];

  initial begin
    int   n;
    int   inj;
    logic [5:0] op, fn;
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
               6'b001010, 6'b001111, 6'b011111, 6'b000010, 6'b000011, 6'b000000};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
               6'b001000, 6'b000000};

    reset = 1'b0;
    Op    = 6'b100011;
    Funct = 6'b000000;
    Zero  = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1'b0, 0);
    step(0, 1'b0, 0);

    run_instr(6'b100011, 6'b000000, 0, -1);  // lw
    run_instr(6'b101011, 6'b000000, 0, -1);  // sw
    run_instr(6'b000000, 6'b100000, 0, -1);  // add
    run_instr(6'b000000, 6'b100010, 0, -1);  // sub
    run_instr(6'b000000, 6'b111111, 0, -1);  // unknown funct
    run_instr(6'b000100, 6'b000000, 1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, -1);  // beq not taken
    run_instr(6'b000101, 6'b000000, 0, -1);  // bne taken
    run_instr(6'b000101, 6'b000000, 1, -1);  // bne not taken
    run_instr(6'b000011, 6'b000000, 0, -1);  // jal
    run_instr(6'b000000, 6'b001000, 0, -1);  // jr
    run_instr(6'b011111, 6'b000000, 0, -1);  // insw
    run_instr(6'b001111, 6'b000000, 0, -1);  // lui
    run_instr(6'b001010, 6'b000000, 0, -1);  // slti
    run_instr(6'b000010, 6'b000000, 0, -1);  // j
    run_instr(6'b111000, 6'b000000, 0, -1);  // illegal
    run_instr(6'b100011, 6'b000000, 0, 4);   // lw, reset in MEMWB
    run_instr(6'b101011, 6'b000000, 0, 3);   // sw, reset in MEMWR

    for (int k = 0; k < 200; k++) begin
      n = $urandom_range(0, 11);
      op = (n == 11) ? 6'($urandom) : op_tab[n];
      n = $urandom_range(0, 6);
      fn = (n == 6) ? 6'($urandom) : fn_tab[n];
      build_seq(op, fn);
      inj = ($urandom_range(0, 9) == 0) ? $urandom_range(0, seq_len - 1) : -1;
      run_instr(op, fn, 2, inj);
    end

    for (int w = 0; w < 8 && q.size() != 0; w++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
